btn_pulse: RTL
==============

# btn_pulse

Pushbutton input conditioner: the input-side counterpart to the LED-driving blocks on the board. Synchronises a raw asynchronous pushbutton, debounces it, and emits single-cycle press/release strobes plus a long-press hold flag. Sits between a board button pin and any control FSM that needs clean, one-cycle button events at the 100 MHz system clock.

## Interface
- `DEBOUNCE_CYCLES`, 500000, consecutive disagreeing synchronised samples needed to accept a level change (5 ms @ 100 MHz); ≥1
- `HOLD_CYCLES`, 50000000, cycles from PRESS to HOLD assertion (0.5 s); ≥1
- `REPEAT_CYCLES`, 10000000, auto-repeat period while held (used only with `BTN_AUTOREPEAT_EN`); ≥1
- `CLOCK` in 1 system clock; all logic on rising edge
- `RESET` in 1 synchronous, active-high reset
- `BTN` in 1 raw, asynchronous, bouncy button level (1 = pressed)
- `LEVEL` out 1 debounced button level
- `PRESS` out 1 one-cycle strobe on accepted press (and auto-repeats)
- `RELEASE` out 1 one-cycle strobe on accepted release
- `HOLD` out 1 high while button held ≥ HOLD_CYCLES

## Operation
- Synchroniser: two flops, `BTN` → s1 → s2. `btn_s` = s2. No other logic touches `BTN`.
- Debounce: counter `db_cnt` increments each cycle `btn_s != LEVEL` and clears to 0 when they are equal. When `btn_s != LEVEL` and `db_cnt == DEBOUNCE_CYCLES-1`, set `LEVEL <= btn_s` and `db_cnt <= 0`. Any single agreeing sample restarts the count.
- Counter widths: `$clog2(param)+1`. No wrap: each counter is cleared before reaching its limit.
- FSM states: IDLE, PRESSED, HELD.
  - IDLE → PRESSED on accepted 0→1 of LEVEL; PRESS=1 that cycle; hold counter cleared.
  - PRESSED: hold counter increments each cycle; → HELD when hold count == HOLD_CYCLES-1.
  - HELD: HOLD=1.
  - PRESSED/HELD → IDLE on accepted 1→0 of LEVEL; RELEASE=1 that cycle; HOLD drops.
- PRESS and RELEASE are never asserted in the same cycle, and are never high for two consecutive cycles.
- Reset: s1, s2, LEVEL, PRESS, RELEASE, HOLD = 0, all counters = 0, state IDLE. If BTN is still high when RESET deasserts, it is treated as a fresh press after the normal latency.
- Reset mid-operation (any state) aborts immediately. No RELEASE strobe is emitted for the aborted press.

## Timing
- Clean press: BTN rises before edge 1 and stays stable. s2 = 1 after edge 2. LEVEL and PRESS go high on edge DEBOUNCE_CYCLES+2.
- Release latency is identical: RELEASE asserts and LEVEL and HOLD fall on edge DEBOUNCE_CYCLES+2 after BTN falls.
- HOLD rises exactly HOLD_CYCLES edges after the edge on which PRESS rose.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- All outputs are registered. There are no combinational paths from BTN.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - On entry to HELD, PRESS pulses in the same cycle HOLD rises.
  - After that, PRESS pulses every REPEAT_CYCLES cycles while in HELD.
  - The repeat counter clears on HELD entry and on release.
- `BTN_AUTOREPEAT_EN` undefined: PRESS pulses only once per accepted press. The repeat counter and `REPEAT_CYCLES` logic are absent.

## Test plan
Bench settings: 10 ns clock, `DEBOUNCE_CYCLES=4`, `HOLD_CYCLES=20`, `REPEAT_CYCLES=8`. Edge numbers count from the first edge after the BTN change.
- Reset: assert RESET 3 cycles with BTN=1 → all outputs 0. After deassert, PRESS rises at edge 6 from deassert.
- Bounce: BTN high 3 cycles, low 1, high 2, low → LEVEL, PRESS, RELEASE stay 0 throughout.
- Clean press: BTN high from edge 1 → LEVEL=1 and PRESS=1 at edge 6 only. PRESS=0 at edge 7.
- Hold: keep BTN high → HOLD rises at edge 26.
  - With macro: extra PRESS strobes at edges 26, 34, 42.
  - Without macro: no further PRESS.
- Release: drop BTN at edge 50 → RELEASE, LEVEL=0 and HOLD=0 at edge 56. No PRESS after that.
- Reset mid-hold: RESET at edge 30 of a held press → HOLD and LEVEL = 0 next edge, no RELEASE. After deassert with BTN still high, PRESS fires 6 edges later.

Source files
------------

// File: rtl/btn_pulse.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_pulse - pushbutton synchroniser/debouncer with PRESS, RELEASE, HOLD.
// Optional macro BTN_AUTOREPEAT_EN: PRESS auto-repeats while held. Rev 1.0
// ----------------------------------------------------------------------------
module btn_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("btn_pulse: cycle parameters must all be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  logic [1:0]        sync_q;
  logic              level_q, level_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              hold_q, hold_d;

  logic w_differ;
  logic w_accept;
  logic w_rise;
  logic w_fall;

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) rep_cnt_q <= '0;
    else         rep_cnt_q <= rep_cnt_d;
  end
`endif

  // Acceptance is decoded one cycle early so LEVEL and the strobes change on the same edge.
  assign w_differ = (sync_q[1] != level_q);
  assign w_accept = w_differ && (db_cnt_q == DB_LAST);
  assign w_rise   = w_accept && sync_q[1];
  assign w_fall   = w_accept && !sync_q[1];

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (w_differ) begin
      if (w_accept) level_d  = sync_q[1];
      else          db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    hold_d     = hold_q;
`ifdef BTN_AUTOREPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_rise) begin
          state_d    = ST_PRESSED;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      ST_PRESSED: begin
        if (w_fall) begin
          state_d    = ST_IDLE;
          release_d  = 1'b1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_HELD;
          hold_d     = 1'b1;
          hold_cnt_d = '0;
`ifdef BTN_AUTOREPEAT_EN
          press_d    = 1'b1;
          rep_cnt_d  = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_HELD: begin
        if (w_fall) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          hold_d    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
          rep_cnt_d = '0;
        end else if (rep_cnt_q == REP_LAST) begin
          press_d   = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q     <= '0;
      level_q    <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_i};
      level_q    <= level_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      hold_q     <= hold_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;

endmodule
`default_nettype wire
